// File: rtl/arc4_prga_if.sv
// Handshake and memory-port bundle between the ARC4 PRGA stage and its
// controller / S, ciphertext and plaintext memories.
interface arc4_prga_if;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr;
  logic [7:0] s_rddata;
  logic [7:0] s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr;
  logic [7:0] ct_rddata;
  logic [7:0] pt_addr;
  logic [7:0] pt_wrdata;
  logic       pt_wren;

  // Controller and memories side
  modport master (
    output en, s_rddata, ct_rddata,
    input  rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
  );

  // PRGA stage side
  modport slave (
    input  en, s_rddata, ct_rddata,
    output rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
  );
endinterface

// File: rtl/arc4_prga.sv
// ARC4 pseudo-random generation stage: walks length-prefixed ciphertext,
// swaps S entries and writes length-prefixed plaintext (6 cycles per byte).
module arc4_prga (
  input  logic        clk,
  input  logic        rst,
  arc4_prga_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE, LEN_RD, LEN_WR, RD_I, RD_J, SW_I, SW_J, RD_PAD, WR_PT
  } state_t;

  state_t     state, state_nx;
  logic [7:0] j, k, len, si, sj, ct_byte;
  logic [7:0] j_sum, pad_addr;

  assign j_sum    = j + bus.s_rddata;
  assign pad_addr = si + sj;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and memory-port outputs; undriven outputs default to 0
  always_comb begin
    state_nx      = state;
    bus.rdy       = 1'b0;
    bus.s_addr    = '0;
    bus.s_wrdata  = '0;
    bus.s_wren    = 1'b0;
    bus.ct_addr   = '0;
    bus.pt_addr   = '0;
    bus.pt_wrdata = '0;
    bus.pt_wren   = 1'b0;
    case (state)
      IDLE: begin
        bus.rdy = 1'b1;
        if (bus.en) state_nx = LEN_RD;
      end
      LEN_RD: begin
        bus.ct_addr = '0;
        state_nx    = LEN_WR;
      end
      LEN_WR: begin
        bus.pt_addr   = '0;
        bus.pt_wrdata = bus.ct_rddata;
        bus.pt_wren   = 1'b1;
        state_nx      = (bus.ct_rddata == 8'd0) ? IDLE : RD_I;
      end
      RD_I: begin
        bus.s_addr  = k;
        bus.ct_addr = k;
        state_nx    = RD_J;
      end
      RD_J: begin
        bus.s_addr = j_sum;
        state_nx   = SW_I;
      end
      SW_I: begin
        bus.s_addr   = k;
        bus.s_wrdata = bus.s_rddata;
        bus.s_wren   = 1'b1;
        state_nx     = SW_J;
      end
      SW_J: begin
        bus.s_addr   = j;
        bus.s_wrdata = si;
        bus.s_wren   = 1'b1;
        state_nx     = RD_PAD;
      end
      RD_PAD: begin
        bus.s_addr = pad_addr;
        state_nx   = WR_PT;
      end
      WR_PT: begin
        bus.pt_addr   = k;
        bus.pt_wrdata = bus.s_rddata ^ ct_byte;
        bus.pt_wren   = 1'b1;
        state_nx      = (k == len) ? IDLE : RD_I;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath registers: indices, length and captured S / ct bytes
  always_ff @(posedge clk) begin
    if (rst) begin
      j       <= '0;
      k       <= 8'd1;
      len     <= '0;
      si      <= '0;
      sj      <= '0;
      ct_byte <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.en) begin
            j <= '0;
            k <= 8'd1;
          end
        end
        LEN_WR: len <= bus.ct_rddata;
        RD_J: begin
          si      <= bus.s_rddata;
          ct_byte <= bus.ct_rddata;
          j       <= j_sum;
        end
        SW_I:  sj <= bus.s_rddata;
        WR_PT: if (k != len) k <= k + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_prga.sv
// Self-checking bench for arc4_prga with a scoreboard of expected pt writes.
module tb_arc4_prga;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load = 1'b0;
  always #5 clk = ~clk;

  arc4_prga_if bus ();
  arc4_prga dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] s_mem  [256];
  logic [7:0] s_img  [256];
  logic [7:0] ct_mem [256];
  logic [7:0] pt_mem [256];
  logic [7:0] exp_s  [256];
  logic [15:0] sb [$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Single-port synchronous memories; load copies the S image and clears pt
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) begin
        s_mem[i]  <= s_img[i];
        pt_mem[i] <= 8'hEE;
      end
    end else begin
      if (bus.s_wren)  s_mem[bus.s_addr]   <= bus.s_wrdata;
      if (bus.pt_wren) pt_mem[bus.pt_addr] <= bus.pt_wrdata;
    end
    bus.s_rddata  <= s_mem[bus.s_addr];
    bus.ct_rddata <= ct_mem[bus.ct_addr];
  end

  // Scoreboard consumer: every pt write must match the next expected one
  always @(negedge clk) begin
    if (!rst && bus.pt_wren) begin
      if (sb.size() == 0) check("pt_unexpected", {31'd0, bus.pt_wren}, 32'd0);
      else check("pt_write", {16'd0, bus.pt_addr, bus.pt_wrdata}, {16'd0, sb.pop_front()});
    end
  end

  task automatic load_mem();
    @(negedge clk);
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  // Software ARC4-PRGA on the current S contents; pushes expected pt writes
  task automatic model_push(input int len);
    logic [7:0] ms [256];
    logic [7:0] jj, si, sj, pad, kk;
    for (int i = 0; i < 256; i++) ms[i] = s_mem[i];
    sb.push_back({8'd0, 8'(len)});
    jj = 8'd0;
    for (int k = 1; k <= len; k++) begin
      kk     = 8'(k);
      si     = ms[kk];
      jj     = jj + si;
      sj     = ms[jj];
      ms[kk] = sj;
      ms[jj] = si;
      pad    = ms[8'(si + sj)];
      sb.push_back({kk, pad ^ ct_mem[kk]});
    end
    for (int i = 0; i < 256; i++) exp_s[i] = ms[i];
  endtask

  task automatic run(input int len, input int pulse_at, input bit hold);
    int cycles;
    int nbad;
    @(negedge clk);
    check("rdy_before_start", {31'd0, bus.rdy}, 32'd1);
    model_push(len);
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    check("rdy_after_accept", {31'd0, bus.rdy}, 32'd0);
    if (!hold) bus.en = 1'b0;
    cycles = 0;
    while (!bus.rdy && cycles < 3000) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == pulse_at) bus.en = 1'b1;
      else if (!hold)         bus.en = 1'b0;
    end
    check("busy_cycles", cycles, 2 + 6 * len);
    check("sb_drained", sb.size(), 0);
    nbad = 0;
    for (int i = 0; i < 256; i++) if (s_mem[i] !== exp_s[i]) nbad++;
    check("s_final", nbad, 0);
  endtask

  initial begin
    int nsw;
    bus.en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      s_img[i]  = 8'(i);
      ct_mem[i] = 8'd0;
    end

    // Reset held with en high: idle, no enables, all ports 0
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_rdy", {31'd0, bus.rdy}, 32'd1);
      check("rst_outputs", {bus.s_wren, bus.pt_wren, bus.s_addr, bus.ct_addr, bus.pt_addr},
            32'd0);
    end
    rst = 1'b0;
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    check("no_start_after_rst", {31'd0, bus.rdy}, 32'd1);

    // L = 0
    load_mem();
    run(0, -1, 1'b0);
    check("l0_pt0", {24'd0, pt_mem[0]}, 32'd0);

    // Identity S, three bytes, against hand-derived values
    ct_mem[0] = 8'h03; ct_mem[1] = 8'h41; ct_mem[2] = 8'h42; ct_mem[3] = 8'h43;
    load_mem();
    run(3, -1, 1'b0);
    check("id_pt0", {24'd0, pt_mem[0]}, 32'h03);
    check("id_pt1", {24'd0, pt_mem[1]}, 32'h43);
    check("id_pt2", {24'd0, pt_mem[2]}, 32'h47);
    check("id_pt3", {24'd0, pt_mem[3]}, 32'h44);
    check("id_s2",  {24'd0, s_mem[2]},  32'h03);
    check("id_s3",  {24'd0, s_mem[3]},  32'h05);
    check("id_s5",  {24'd0, s_mem[5]},  32'h02);

    // Full length, random ciphertext; j and sums wrap
    ct_mem[0] = 8'd255;
    for (int i = 1; i < 256; i++) ct_mem[i] = 8'($urandom);
    load_mem();
    run(255, -1, 1'b0);

    // Reset during SW_I of byte 2, then restart on the altered S
    ct_mem[0] = 8'd5;
    for (int i = 1; i < 6; i++) ct_mem[i] = 8'($urandom);
    load_mem();
    @(negedge clk);
    model_push(5);
    bus.en = 1'b1;
    @(posedge clk);
    #1 bus.en = 1'b0;
    nsw = 0;
    for (int c = 0; c < 100 && nsw < 3; c++) begin
      @(negedge clk);
      if (bus.s_wren) nsw++;
    end
    check("sw_i_reached", nsw, 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_rdy", {31'd0, bus.rdy}, 32'd1);
    check("midrst_wren", {30'd0, bus.s_wren, bus.pt_wren}, 32'd0);
    rst = 1'b0;
    check("midrst_sb_left", sb.size(), 4);
    sb.delete();
    run(5, -1, 1'b0);

    // en pulsed mid-run has no effect
    ct_mem[0] = 8'd4;
    for (int i = 1; i < 5; i++) ct_mem[i] = 8'($urandom);
    load_mem();
    run(4, 7, 1'b0);

    // en held across completion: immediate second run with j restarted
    ct_mem[0] = 8'd3;
    for (int i = 1; i < 4; i++) ct_mem[i] = 8'($urandom);
    load_mem();
    run(3, -1, 1'b1);
    run(3, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
